// File: rtl/dmem_store_port_if.sv
// Store/read bus between the single-cycle core and the data memory responder.
// The core drives the store request; the memory answers with the addressed word.
interface dmem_store_port_if;
    logic [1:0]  memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output memwrite, output dataadr, output writedata, input readdata);
    modport slave  (input memwrite, input dataadr, input writedata, output readdata);
endinterface

// File: rtl/dmem_store_port.sv
// Data memory responder: byte/halfword/word stores with lane merge, alignment and
// range checks, a zero-fill sweep after reset, a sticky fault flag and a store counter.
module dmem_store_port #(
    parameter int DEPTH_WORDS = 64,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_store_port_if.slave     bus,
    output logic                 busy,
    output logic                 fault,
    output logic [CNT_W-1:0]     storecount
);
    localparam int              AW        = $clog2(DEPTH_WORDS);
    localparam logic [29:0]     DEPTH_LIM = 30'(DEPTH_WORDS);
    localparam logic [AW-1:0]   LAST_IDX  = AW'(DEPTH_WORDS - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t          state;
    logic [AW-1:0]   sweep_idx;
    logic [31:0]     mem [DEPTH_WORDS];

    logic [29:0]     widx;
    logic            in_range;
    logic            aligned;
    logic            accept;
    logic            reject;
    logic [3:0]      lane_en;
    logic [31:0]     lane_data;

    assign widx     = bus.dataadr[31:2];
    assign in_range = widx < DEPTH_LIM;

    // Replicating the store data across lanes lets every lane take its byte from the same position.
    always_comb begin
        aligned   = 1'b1;
        lane_en   = 4'b0000;
        lane_data = bus.writedata;
        case (bus.memwrite)
            2'b01: begin
                lane_en   = 4'b0001 << bus.dataadr[1:0];
                lane_data = {4{bus.writedata[7:0]}};
            end
            2'b10: begin
                aligned   = ~bus.dataadr[0];
                lane_en   = bus.dataadr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{bus.writedata[15:0]}};
            end
            2'b11: begin
                aligned   = (bus.dataadr[1:0] == 2'b00);
                lane_en   = 4'b1111;
            end
            default: ;
        endcase
    end

    assign accept = (state == READY) && (bus.memwrite != 2'b00) && in_range && aligned;
    assign reject = (bus.memwrite != 2'b00) && !accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= CLEAR;
            sweep_idx  <= '0;
            busy       <= 1'b1;
            fault      <= 1'b0;
            storecount <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    sweep_idx <= sweep_idx + 1'b1;
                    if (sweep_idx == LAST_IDX) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                READY: ;
                default: state <= CLEAR;
            endcase
            if (reject)
                fault <= 1'b1;
            if (accept && (storecount != '1))
                storecount <= storecount + 1'b1;
        end
    end

    // The array has no reset; the sweep is what re-zeroes it.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[sweep_idx] <= '0;
        end else if (accept) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_en[k])
                    mem[widx[AW-1:0]][8*k +: 8] <= lane_data[8*k +: 8];
            end
        end
    end

    always_comb begin
        bus.readdata = '0;
        if (!busy && in_range)
            bus.readdata = mem[widx[AW-1:0]];
    end
endmodule

// File: tb/tb_dmem_store_port.sv
// Self-checking bench for dmem_store_port: a vector table, hand-written reset/sweep
// sequences and randomized stores checked against a byte-array reference model.
module tb_dmem_store_port;
    localparam int DEPTH = 64;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             busy;
    logic             fault;
    logic [CNT_W-1:0] storecount;

    dmem_store_port_if bus ();

    dmem_store_port #(.DEPTH_WORDS(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .fault      (fault),
        .storecount (storecount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] mbytes [DEPTH*4];
    bit         mfault;
    int         mcount;

    typedef struct {
        logic [1:0]  mw;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        flt;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vecs [8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] mw, input logic [31:0] adr, input logic [31:0] wd);
        bus.memwrite  = mw;
        bus.dataadr   = adr;
        bus.writedata = wd;
    endtask

    function automatic logic [31:0] modelRead(input logic [31:0] adr);
        int w;
        if ((adr / 4) >= DEPTH)
            return 32'h0;
        w = int'(adr & ~32'h3);
        return {mbytes[w+3], mbytes[w+2], mbytes[w+1], mbytes[w]};
    endfunction

    task automatic modelStore(input logic [1:0] mw, input logic [31:0] adr, input logic [31:0] wd);
        int sz;
        if (mw == 2'b00)
            return;
        sz = 1 << (int'(mw) - 1);
        if (((adr / 4) < DEPTH) && ((adr % sz) == 0)) begin
            for (int b = 0; b < sz; b++)
                mbytes[int'(adr) + b] = 8'(wd >> (8 * b));
            if (mcount < CNT_MAX)
                mcount++;
        end else begin
            mfault = 1'b1;
        end
    endtask

    task automatic waitSweep();
        int n = 0;
        applyStimulus(2'b00, 32'd84, 32'h0);
        while (n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1)
                checkOutput("rd_during_sweep", bus.readdata, 32'h0);
            if (!busy)
                break;
        end
        checkOutput("sweep_len", 32'(n), 32'd64);
    endtask

    task automatic doReset();
        reset = 1'b0;
        applyStimulus(2'b00, 32'd84, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd1);
        checkOutput("rst_fault", 32'(fault), 32'd0);
        checkOutput("rst_count", 32'(storecount), 32'd0);
        checkOutput("rst_rd", bus.readdata, 32'h0);
        for (int i = 0; i < DEPTH * 4; i++)
            mbytes[i] = 8'h00;
        mfault = 1'b0;
        mcount = 0;
        reset  = 1'b1;
        waitSweep();
    endtask

    task automatic doStoreCheck(input string name, input logic [1:0] mw, input logic [31:0] adr, input logic [31:0] wd);
        applyStimulus(mw, adr, wd);
        #1;
        checkOutput({name, "_rd_old"}, bus.readdata, modelRead(adr));
        @(posedge clk);
        modelStore(mw, adr, wd);
        #1;
        checkOutput({name, "_rd"}, bus.readdata, modelRead(adr));
        checkOutput({name, "_fault"}, 32'(fault), 32'(mfault));
        checkOutput({name, "_count"}, 32'(storecount), 32'(mcount));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{2'b11, 32'd84,  32'hFFFF7F02, 32'hFFFF7F02, 1'b0, 4'd1};
        vecs[1] = '{2'b01, 32'd85,  32'h000000AB, 32'hFFFFAB02, 1'b0, 4'd2};
        vecs[2] = '{2'b10, 32'd86,  32'h00001234, 32'h1234AB02, 1'b0, 4'd3};
        vecs[3] = '{2'b11, 32'd86,  32'h11111111, 32'h1234AB02, 1'b1, 4'd3};
        vecs[4] = '{2'b01, 32'd0,   32'hCCCCCC55, 32'h00000055, 1'b1, 4'd4};
        vecs[5] = '{2'b10, 32'd2,   32'h7777BEEF, 32'hBEEF0055, 1'b1, 4'd5};
        vecs[6] = '{2'b11, 32'd256, 32'hA5A5A5A5, 32'h00000000, 1'b1, 4'd5};
        vecs[7] = '{2'b00, 32'd84,  32'hFFFFFFFF, 32'h1234AB02, 1'b1, 4'd5};

        reset = 1'b0;
        applyStimulus(2'b00, 32'd0, 32'h0);
        @(posedge clk);
        #1;

        doReset();
        checkOutput("post_sweep_rd84", bus.readdata, 32'h0);
        checkOutput("post_sweep_fault", 32'(fault), 32'd0);
        checkOutput("post_sweep_count", 32'(storecount), 32'd0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].mw, vecs[i].adr, vecs[i].wd);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_rd", i), bus.readdata, vecs[i].rd);
            checkOutput($sformatf("vec%0d_fault", i), 32'(fault), 32'(vecs[i].flt));
            checkOutput($sformatf("vec%0d_count", i), 32'(storecount), 32'(vecs[i].cnt));
        end

        doReset();
        applyStimulus(2'b10, 32'd85, 32'h00001234);
        @(posedge clk);
        #1;
        checkOutput("misaligned_half_fault", 32'(fault), 32'd1);
        checkOutput("misaligned_half_count", 32'(storecount), 32'd0);

        doReset();
        applyStimulus(2'b11, 32'd256, 32'h12345678);
        @(posedge clk);
        #1;
        checkOutput("oor_word_fault", 32'(fault), 32'd1);
        checkOutput("oor_word_rd", bus.readdata, 32'h0);

        // A store on the 10th edge after release must be rejected by the sweep.
        reset = 1'b0;
        applyStimulus(2'b00, 32'd0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        applyStimulus(2'b11, 32'd0, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        applyStimulus(2'b00, 32'd0, 32'h0);
        checkOutput("sweep_store_fault", 32'(fault), 32'd1);
        begin
            int n = 0;
            while (busy && n < 200) begin
                @(posedge clk);
                n++;
                #1;
            end
            checkOutput("sweep_store_sweep_rest", 32'(n), 32'd54);
        end
        checkOutput("sweep_store_rd0", bus.readdata, 32'h0);
        checkOutput("sweep_store_count", 32'(storecount), 32'd0);

        doReset();
        doStoreCheck("midop_store", 2'b11, 32'd84, 32'hFFFF7F02);
        doReset();
        checkOutput("midop_rd84", bus.readdata, 32'h0);
        checkOutput("midop_count", 32'(storecount), 32'd0);

        for (int r = 0; r < 3; r++) begin
            doReset();
            for (int i = 0; i < 120; i++) begin
                logic [1:0]  mw;
                logic [31:0] adr;
                logic [31:0] wd;
                mw  = 2'($urandom_range(0, 3));
                adr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 280));
                wd  = $urandom;
                doStoreCheck($sformatf("rnd%0d_%0d", r, i), mw, adr, wd);
            end
            applyStimulus(2'b00, 32'd0, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_store_port.md
# dmem_store_port

Data-memory responder on the CPU's store interface: accepts `memwrite`/`dataadr`/`writedata` from the single-cycle core and serves `readdata` back. Supports byte, halfword and word stores with lane selection, alignment and range checking. After reset it zero-fills the array with a sequential sweep. It sits beside the core in `top`, on the opposite end of the bus that the testbench monitors.

## Interface

- `DEPTH_WORDS`, 64: number of 32-bit words; power of two, 4..1024.
- `CNT_W`, 16: width of the accepted-store counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `memwrite` in 2: store size. 00 none, 01 byte, 10 halfword, 11 word.
- `dataadr` in 32: byte address from the core.
- `writedata` in 32: store data from the core.
- `readdata` out 32: word at `dataadr[31:2]`.
- `busy` out 1: clear sweep in progress.
- `fault` out 1: sticky error flag.
- `storecount` out CNT_W: number of accepted stores, saturating.

## Operation

- FSM states:
  - CLEAR: entered on reset. Writes zero to word `sweep_idx` each cycle, with `sweep_idx` running 0..DEPTH_WORDS-1. After the write of DEPTH_WORDS-1, goes to READY.
  - READY: services stores. Never leaves except on reset.
- Word index `widx` = `dataadr[31:2]`. The address is in range iff `widx < DEPTH_WORDS`.
- Store accept condition: state READY, `memwrite != 00`, address in range, and the access is aligned.
  - Halfword requires `dataadr[0]=0`.
  - Word requires `dataadr[1:0]=00`.
  - Byte is always aligned.
- Byte lanes are little-endian. Lane k is bits [8k+7:8k], with k = `dataadr[1:0]`.
  - Byte store: writes `writedata[7:0]` to lane k.
  - Halfword store: writes `writedata[15:0]` to lanes 2h and 2h+1, with h = `dataadr[1]`.
  - Word store: writes all four lanes from `writedata`.
  - Unselected lanes hold their value.
- Rejected store (`memwrite != 00` with out-of-range address, misaligned access, or state CLEAR):
  - No array write.
  - `fault` is set to 1 and stays at 1 until reset.
  - `storecount` does not change.
- Each accepted store increments `storecount` by 1. It saturates at all-ones and does not wrap.
- `readdata` is combinational from the array. It reads 0 when the address is out of range or `busy` is 1.
  - Reads ignore `dataadr[1:0]`.
  - Reads never set `fault`.
- Reset asserted mid-sweep or mid-operation:
  - State returns to CLEAR and `sweep_idx` returns to 0.
  - Counters and flags clear.
  - Array contents are not reset asynchronously; the sweep re-zeroes them.

## Timing

- Output values while `reset` is low: `busy`=1, `fault`=0, `storecount`=0, `readdata`=0.
- Sweep duration: `busy` stays at 1 for exactly DEPTH_WORDS rising edges after `reset` goes high.
  - The first edge after release writes word 0.
  - The edge that writes word DEPTH_WORDS-1 also drives `busy` to 0.
- Store latency: the array updates on the same rising edge that samples `memwrite != 00`.
  - `readdata` for that word reflects the new value after that edge (zero-cycle combinational read of registered contents).
  - Same-cycle read-during-write returns the old value.
- `fault` and `storecount` update on the same edge as the store they account for.
- `memwrite` is sampled every edge. There is no handshake; the core must not depend on `busy` (the bench holds stores off until `busy`=0).

## Test plan

- Reset and sweep: with DEPTH_WORDS=64, release `reset` -> `busy`=1 for 64 edges and 0 at edge 64. `readdata` at `dataadr`=84 reads 0. `fault`=0, `storecount`=0.
- Word store: `memwrite`=11, `dataadr`=84, `writedata`=FFFF7F02 -> next cycle `readdata`=FFFF7F02 and `storecount`=1.
- Lane merge, starting from word 84 = FFFF7F02:
  - Byte store 0x000000AB at `dataadr`=85 -> `readdata`=FFFFAB02.
  - Then halfword store 0x00001234 at `dataadr`=86 -> `readdata`=1234AB02. `storecount`=3.
- Faults:
  - Word store at `dataadr`=86 -> word 84 unchanged, `fault`=1, `storecount` unchanged.
  - After reset, halfword store at `dataadr`=85 -> `fault`=1.
  - After reset, word store at `dataadr`=256 -> `fault`=1, `readdata`=0.
- Store during sweep: `memwrite`=11 at `dataadr`=0 on the 10th edge after release -> `fault`=1 and word 0 reads 0 after the sweep.
- Reset mid-operation: store FFFF7F02 to 84, assert `reset` for 3 cycles, release -> `busy`=1 for 64 edges. Then word 84 reads 0 and `storecount`=0.
